// File: rtl/serial_7seg_receiver_pkg.sv
// serial_7seg_receiver_pkg: constants shared by the 7-segment serial receiver
// and the transmit-side encoder. These are the segment patterns for digits 0-9,
// the decimal-point bit position and the frame-state encoding.
package serial_7seg_receiver_pkg;

  // Position of the decimal point in a segment byte {dp,g,f,e,d,c,b,a}.
  localparam int DP_BIT = 7;

  // Segment patterns for digits 9 down to 0. Index the array with the digit value.
  localparam logic [9:0][7:0] SEG_CODES = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  // States of the frame receiver.
  typedef enum logic [1:0] {
    FRAME_IDLE    = 2'd0,
    FRAME_SHIFT   = 2'd1,
    FRAME_OVERRUN = 2'd2
  } frame_state_t;

endpackage

// File: rtl/serial_7seg_receiver_seg7_to_bcd.sv
// seg7_to_bcd: combinational decoder from one digit's g..a segments to BCD.
// It is only built when SERIAL_RX_DECODE_EN is defined. A pattern that matches
// no digit gives 4'hF and sets the invalid flag.
`ifdef SERIAL_RX_DECODE_EN
module seg7_to_bcd
  import serial_7seg_receiver_pkg::*;
(
  input  logic [DP_BIT-1:0] seg,
  output logic [3:0]        bcd,
  output logic              invalid
);

  // Compare against every known digit pattern. Fall back to "invalid" when none matches.
  always_comb begin
    bcd     = 4'hF;
    invalid = 1'b1;
    for (int d = 0; d < 10; d++) begin
      if (seg == SEG_CODES[d][DP_BIT-1:0]) begin
        bcd     = 4'(d);
        invalid = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/serial_7seg_receiver.sv
// serial_7seg_receiver: receives frames of NUM_DIGITS segment bytes over an
// asynchronous three-wire link (data, shift clock, latch). A frame commits to
// o_segments only if exactly 8*NUM_DIGITS bits arrived before the latch.
// Build option: define SERIAL_RX_DECODE_EN to add per-digit BCD decoding.
// Without it, o_bcd and o_digit_invalid are tied low.
module serial_7seg_receiver
  import serial_7seg_receiver_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_serial_data,
  input  logic                    i_serial_clk,
  input  logic                    i_serial_latch,
  output logic [8*NUM_DIGITS-1:0] o_segments,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic [NUM_DIGITS-1:0]   o_digit_invalid,
  output logic                    o_frame_stb,
  output logic                    o_frame_err,
  output logic                    o_busy
);

  localparam int FRAME_BITS = 8 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t FRAME_CNT = cnt_t'(FRAME_BITS);
  localparam cnt_t OVER_CNT  = cnt_t'(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] data_sync, clk_sync, latch_sync;
  logic                   clk_prev, latch_prev;
  logic                   clk_rise_q, latch_rise_q, data_q;
  logic [FRAME_BITS-1:0]  shift_q, shift_next;
  cnt_t                   cnt_q, cnt_shift;
  logic                   frame_ok;
  frame_state_t           state_q, state_next;

  // Bring the three asynchronous serial wires into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_sync  <= '0;
      clk_sync   <= '0;
      latch_sync <= '0;
    end else begin
      data_sync  <= {data_sync[SYNC_STAGES-2:0], i_serial_data};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], i_serial_clk};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], i_serial_latch};
    end
  end

  // Register rising-edge pulses. The data bit is delayed with them so it stays aligned with its clock edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      clk_prev     <= 1'b0;
      latch_prev   <= 1'b0;
      clk_rise_q   <= 1'b0;
      latch_rise_q <= 1'b0;
      data_q       <= 1'b0;
    end else begin
      clk_prev     <= clk_sync[SYNC_STAGES-1];
      latch_prev   <= latch_sync[SYNC_STAGES-1];
      clk_rise_q   <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
      latch_rise_q <= latch_sync[SYNC_STAGES-1] & ~latch_prev;
      data_q       <= data_sync[SYNC_STAGES-1];
    end
  end

  // Apply any shift before judging a latch, so a bit arriving with the latch still counts.
  always_comb begin
    shift_next = shift_q;
    cnt_shift  = cnt_q;
    if (clk_rise_q) begin
      shift_next = {shift_q[FRAME_BITS-2:0], data_q};
      cnt_shift  = (cnt_q == OVER_CNT) ? cnt_q : cnt_q + cnt_t'(1);
    end
    frame_ok = latch_rise_q && (cnt_shift == FRAME_CNT);
  end

  // Shift register, bit counter, committed frame and the one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      o_segments  <= '0;
      o_frame_stb <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      shift_q     <= shift_next;
      cnt_q       <= latch_rise_q ? '0 : cnt_shift;
      o_frame_stb <= frame_ok;
      o_frame_err <= latch_rise_q & ~frame_ok;
      if (frame_ok) begin
        o_segments <= shift_next;
      end
    end
  end

`ifdef SERIAL_RX_DECODE_EN
  logic [4*NUM_DIGITS-1:0] bcd_next;
  logic [NUM_DIGITS-1:0]   invalid_next;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decode
    seg7_to_bcd u_dec (
      .seg     (shift_next[g*8 +: DP_BIT]),
      .bcd     (bcd_next[g*4 +: 4]),
      .invalid (invalid_next[g])
    );
  end

  // Capture the decoded digits at the same moment as the segment bytes they came from.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_bcd           <= '0;
      o_digit_invalid <= '0;
    end else if (frame_ok) begin
      o_bcd           <= bcd_next;
      o_digit_invalid <= invalid_next;
    end
  end
`else
  assign o_bcd           = '0;
  assign o_digit_invalid = '0;
`endif

  // Frame state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= FRAME_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // A latch always returns to idle. Shift-clock edges move through the shift and overrun states.
  always_comb begin
    state_next = state_q;
    if (latch_rise_q) begin
      state_next = FRAME_IDLE;
    end else if (clk_rise_q) begin
      case (state_q)
        FRAME_IDLE:    state_next = FRAME_SHIFT;
        FRAME_SHIFT:   state_next = (cnt_shift == OVER_CNT) ? FRAME_OVERRUN : FRAME_SHIFT;
        FRAME_OVERRUN: state_next = FRAME_OVERRUN;
        default:       state_next = FRAME_IDLE;
      endcase
    end
  end

  // Busy whenever a frame is partially or over-received.
  always_comb begin
    o_busy = (state_q != FRAME_IDLE);
  end

endmodule
